// File: rtl/vr_tx_arb_pkg.sv
// Shared types for the UDP TX port arbiter: FSM state encoding and engine count default.
package vr_tx_arb_pkg;

    localparam int NUM_SRC_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_META = 2'd1,
        ST_SEND_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vr_udp_tx_arb_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at N.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx
);

    int e;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        e       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            e = (int'(ptr) + k) % N;
            if (req[e]) begin
                gnt_oh    = '0;
                gnt_oh[e] = 1'b1;
                gnt_idx   = IW'(e);
            end
        end
    end

endmodule

// File: rtl/vr_udp_tx_arb.sv
// Round-robin arbiter sharing one UDP TX port (meta word then data beats) among NUM_SRC engines.
// Optional per-engine packet counters on output pkt_cnt when VR_TX_ARB_STATS_EN is defined.
module vr_udp_tx_arb
    import vr_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT,
    parameter int META_W  = 96,
    parameter int DATA_W  = 512,
    parameter int IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_meta_val,
    input  logic [NUM_SRC*META_W-1:0] src_meta,
    output logic [NUM_SRC-1:0]        src_meta_rdy,
    input  logic [NUM_SRC-1:0]        src_data_val,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_data_last,
    output logic [NUM_SRC-1:0]        src_data_rdy,
    output logic                      dst_meta_val,
    output logic [META_W-1:0]         dst_meta,
    input  logic                      dst_meta_rdy,
    output logic                      dst_data_val,
    output logic [DATA_W-1:0]         dst_data,
    output logic                      dst_data_last,
    input  logic                      dst_data_rdy,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
    output logic [1:0]                dbg_state
`ifdef VR_TX_ARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]     pkt_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where val and rdy are both high;
    // a source holds val and its payload stable until that edge. rdy may depend on val.

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 meta_hs, data_hs, last_hs;

    rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
        .req     (src_meta_val),
        .ptr     (rr_ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx)
    );

    assign meta_hs = (state_q == ST_SEND_META) && src_meta_val[grant_q] && dst_meta_rdy;
    assign data_hs = (state_q == ST_SEND_DATA) && src_data_val[grant_q] && dst_data_rdy;
    assign last_hs = data_hs && src_data_last[grant_q];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|pick_oh) begin
                    grant_d = pick_idx;
                    state_d = ST_SEND_META;
                end
            end
            ST_SEND_META: begin
                if (meta_hs) state_d = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                if (last_hs) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == IW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Port steering is selected only by registered state and grant.
    always_comb begin
        src_meta_rdy  = '0;
        src_data_rdy  = '0;
        dst_meta_val  = 1'b0;
        dst_meta      = '0;
        dst_data_val  = 1'b0;
        dst_data      = '0;
        dst_data_last = 1'b0;
        case (state_q)
            ST_SEND_META: begin
                dst_meta_val          = src_meta_val[grant_q];
                dst_meta              = src_meta[int'(grant_q)*META_W +: META_W];
                src_meta_rdy[grant_q] = dst_meta_rdy;
            end
            ST_SEND_DATA: begin
                dst_data_val          = src_data_val[grant_q];
                dst_data              = src_data[int'(grant_q)*DATA_W +: DATA_W];
                dst_data_last         = src_data_last[grant_q];
                src_data_rdy[grant_q] = dst_data_rdy;
            end
            default: ;
        endcase
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

`ifdef VR_TX_ARB_STATS_EN
    logic [NUM_SRC*32-1:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (last_hs)
            pkt_cnt_d[int'(grant_q)*32 +: 32] = pkt_cnt_q[int'(grant_q)*32 +: 32] + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) pkt_cnt_q <= '0;
        else     pkt_cnt_q <= pkt_cnt_d;
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_vr_udp_tx_arb.sv
// Bench for vr_udp_tx_arb: directed timing/arbitration scenarios plus randomized traffic
// checked against a transaction-level round-robin model. Define VR_TX_ARB_STATS_EN for counter tests.
module tb_vr_udp_tx_arb;

    localparam int N  = 3;
    localparam int MW = 16;
    localparam int DW = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_meta_val;
    logic [N*MW-1:0] src_meta;
    logic [N-1:0]    src_meta_rdy;
    logic [N-1:0]    src_data_val;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_data_last;
    logic [N-1:0]    src_data_rdy;
    logic            dst_meta_val;
    logic [MW-1:0]   dst_meta;
    logic            dst_meta_rdy;
    logic            dst_data_val;
    logic [DW-1:0]   dst_data;
    logic            dst_data_last;
    logic            dst_data_rdy;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic [1:0]      dbg_state;
`ifdef VR_TX_ARB_STATS_EN
    logic [N*32-1:0] pkt_cnt;
`endif

    vr_udp_tx_arb #(.NUM_SRC(N), .META_W(MW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_meta_val  (src_meta_val),
        .src_meta      (src_meta),
        .src_meta_rdy  (src_meta_rdy),
        .src_data_val  (src_data_val),
        .src_data      (src_data),
        .src_data_last (src_data_last),
        .src_data_rdy  (src_data_rdy),
        .dst_meta_val  (dst_meta_val),
        .dst_meta      (dst_meta),
        .dst_meta_rdy  (dst_meta_rdy),
        .dst_data_val  (dst_data_val),
        .dst_data      (dst_data),
        .dst_data_last (dst_data_last),
        .dst_data_rdy  (dst_data_rdy),
        .grant_id      (grant_id),
        .busy          (busy),
        .dbg_state     (dbg_state)
`ifdef VR_TX_ARB_STATS_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Source-side packets still to drive, and scoreboard copies still expected on dst.
    logic [MW-1:0] tx_meta_q[N][$];
    logic [DW:0]   tx_beat_q[N][$];
    logic [MW-1:0] exp_meta_q[N][$];
    logic [DW:0]   exp_beat_q[N][$];

    int   drv_ph[N];
    logic hm[N];
    logic hd[N];
    int   p_rdy_meta = 100;
    int   p_rdy_data = 100;
    int   p_dval     = 100;
    int   rdy_pat[$];

    // Transaction-level model: who owns the port, which part of the packet is pending, pointer.
    int m_ph;
    int m_g;
    int m_ptr;
    int grant_log[$];
    int pick_cyc[$];
    int meta_cyc[$];
    int done_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic clear_logs();
        grant_log.delete();
        pick_cyc.delete();
        meta_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic enq(input int e, input int nbeats);
        logic [MW-1:0] m;
        logic [DW:0]   b;
        m = MW'($urandom);
        tx_meta_q[e].push_back(m);
        exp_meta_q[e].push_back(m);
        for (int i = 0; i < nbeats; i++) begin
            b = {(i == nbeats - 1), DW'($urandom)};
            tx_beat_q[e].push_back(b);
            exp_beat_q[e].push_back(b);
        end
    endtask

    // Mid-cycle sampling: checks this cycle's outputs and advances the model to the next cycle.
    task automatic mon();
        logic [N-1:0] exp_mrdy;
        logic [N-1:0] exp_drdy;
        logic [DW:0]  b;
        cyc++;
        for (int e = 0; e < N; e++) begin
            hm[e] = !rst && src_meta_val[e] && src_meta_rdy[e];
            hd[e] = !rst && src_data_val[e] && src_data_rdy[e];
        end
        if (rst) return;
        exp_mrdy = '0;
        exp_drdy = '0;
        chk("busy", busy, m_ph != 0);
        if (m_ph == 0) begin
            chk("idle_dst_meta_val", dst_meta_val, 0);
            chk("idle_dst_data_val", dst_data_val, 0);
        end else begin
            chk("grant_id", grant_id, m_g);
            if (m_ph == 1) begin
                exp_mrdy[m_g] = dst_meta_rdy;
                chk("meta_val_fwd", dst_meta_val, src_meta_val[m_g]);
                chk("data_val_in_meta", dst_data_val, 0);
                if (dst_meta_val) begin
                    if (exp_meta_q[m_g].size() == 0) chk("meta_unexpected", 1, 0);
                    else chk("dst_meta", dst_meta, exp_meta_q[m_g][0]);
                end
            end else begin
                exp_drdy[m_g] = dst_data_rdy;
                chk("data_val_fwd", dst_data_val, src_data_val[m_g]);
                chk("meta_val_in_data", dst_meta_val, 0);
                if (dst_data_val) begin
                    if (exp_beat_q[m_g].size() == 0) chk("beat_unexpected", 1, 0);
                    else chk("dst_beat", {dst_data_last, dst_data}, exp_beat_q[m_g][0]);
                end
            end
        end
        chk("src_meta_rdy", src_meta_rdy, exp_mrdy);
        chk("src_data_rdy", src_data_rdy, exp_drdy);
        case (m_ph)
            0: if (|src_meta_val) begin
                m_g  = model_pick(src_meta_val, m_ptr);
                m_ph = 1;
                grant_log.push_back(m_g);
                pick_cyc.push_back(cyc);
            end
            1: if (src_meta_val[m_g] && dst_meta_rdy) begin
                if (exp_meta_q[m_g].size() > 0) void'(exp_meta_q[m_g].pop_front());
                meta_cyc.push_back(cyc);
                m_ph = 2;
            end
            default: if (src_data_val[m_g] && dst_data_rdy) begin
                b = src_data_last[m_g] ? {1'b1, DW'(0)} : '0;
                if (exp_beat_q[m_g].size() > 0) b = exp_beat_q[m_g].pop_front();
                if (b[DW]) begin
                    m_ph  = 0;
                    m_ptr = (m_g + 1) % N;
                    done_cyc.push_back(cyc);
                end
            end
        endcase
    endtask

    // Source engines and sink: update after the edge using the handshakes seen mid-cycle.
    task automatic drv();
        logic [DW:0] b;
        for (int e = 0; e < N; e++) begin
            if (hm[e]) begin
                void'(tx_meta_q[e].pop_front());
                drv_ph[e] = 2;
            end
            if (hd[e]) begin
                b = tx_beat_q[e].pop_front();
                if (b[DW]) drv_ph[e] = 0;
            end
            if (drv_ph[e] == 0 && tx_meta_q[e].size() > 0) drv_ph[e] = 1;
            src_meta_val[e] = (drv_ph[e] == 1);
            src_meta[e*MW +: MW] = (drv_ph[e] == 1) ? tx_meta_q[e][0] : '0;
            if (drv_ph[e] == 2) begin
                if (!(src_data_val[e] && !hd[e]))
                    src_data_val[e] = ($urandom_range(99) < p_dval);
                src_data[e*DW +: DW] = tx_beat_q[e][0][DW-1:0];
                src_data_last[e]     = tx_beat_q[e][0][DW];
            end else begin
                src_data_val[e]      = 1'b0;
                src_data[e*DW +: DW] = '0;
                src_data_last[e]     = 1'b0;
            end
        end
        dst_meta_rdy = ($urandom_range(99) < p_rdy_meta);
        if (rdy_pat.size() > 0 && m_ph == 2) dst_data_rdy = rdy_pat.pop_front() != 0;
        else dst_data_rdy = ($urandom_range(99) < p_rdy_data);
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        drv();
    endtask

    function automatic bit pending();
        bit p;
        p = (m_ph != 0);
        for (int e = 0; e < N; e++)
            if (tx_meta_q[e].size() > 0 || tx_beat_q[e].size() > 0 || drv_ph[e] != 0) p = 1;
        return p;
    endfunction

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (pending() && k < bound) begin
            step();
            k++;
        end
        chk("drain_timeout", k >= bound, 0);
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dst_meta_rdy = 1'b0;
        dst_data_rdy = 1'b0;
        for (int e = 0; e < N; e++) begin
            tx_meta_q[e].delete();
            tx_beat_q[e].delete();
            exp_meta_q[e].delete();
            exp_beat_q[e].delete();
            drv_ph[e] = 0;
        end
        rdy_pat.delete();
        m_ph  = 0;
        m_g   = 0;
        m_ptr = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Called just after the edge that follows reset; samples before the falling edge.
    task automatic reset_checks();
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_src_meta_rdy", src_meta_rdy, 0);
        chk("rst_src_data_rdy", src_data_rdy, 0);
        chk("rst_dst_meta_val", dst_meta_val, 0);
        chk("rst_dst_data_val", dst_data_val, 0);
    endtask

    initial begin
        int t0;
        int k;
        rst = 1'b1;
        src_meta_val = '0; src_meta = '0; src_data_val = '0; src_data = '0;
        src_data_last = '0; dst_meta_rdy = 1'b0; dst_data_rdy = 1'b0;
        for (int e = 0; e < N; e++) begin
            drv_ph[e] = 0; hm[e] = 1'b0; hd[e] = 1'b0;
        end
        m_ph = 0; m_g = 0; m_ptr = 0;
        @(posedge clk);
        #1;
        do_reset();
        reset_checks();

        // Single source, two beats, sink always ready.
        clear_logs();
        t0 = cyc + 1;
        enq(0, 2);
        drain(50);
        chk("t_meta_hs", (meta_cyc.size() > 0) ? meta_cyc[0] - t0 : -1, 2);
        chk("t_last_hs", (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, 4);

        // Contention from reset.
        do_reset();
        clear_logs();
        for (int e = 0; e < N; e++) enq(e, 2);
        drain(100);
        chk("cont_npkts", grant_log.size(), 3);
        for (int i = 0; i < 3 && i < grant_log.size(); i++) chk("cont_order", grant_log[i], i);
        for (int i = 0; i < 2 && i + 1 < pick_cyc.size() && i < done_cyc.size(); i++)
            chk("cont_idle_gap", pick_cyc[i+1] - done_cyc[i], 1);

        // Fairness: engine 2 slots in right after engine 0's current packet.
        do_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) enq(0, 3);
        step(); step(); step();
        enq(2, 1);
        drain(200);
        chk("fair_npkts", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("fair_g0", grant_log[0], 0);
            chk("fair_g1", grant_log[1], 2);
            chk("fair_g2", grant_log[2], 0);
            chk("fair_g3", grant_log[3], 0);
        end

        // Backpressure on a 3-beat packet.
        clear_logs();
        rdy_pat = '{1, 0, 0, 1, 1};
        enq(1, 3);
        drain(100);
        chk("bp_done", done_cyc.size(), 1);
        chk("bp_beats_left", exp_beat_q[1].size(), 0);

        // Reset while beat 2 of 4 is on the port, with the pointer away from zero.
        do_reset();
        clear_logs();
        enq(0, 1);
        drain(50);
        enq(1, 4);
        k = 0;
        while (exp_beat_q[1].size() != 3 && k < 50) begin
            step();
            k++;
        end
        chk("mid_rst_reach_beat2", k >= 50, 0);
        do_reset();
        reset_checks();
        clear_logs();
        enq(0, 1);
        enq(1, 1);
        drain(100);
        chk("post_rst_npkts", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("post_rst_first", grant_log[0], 0);
            chk("post_rst_second", grant_log[1], 1);
        end

`ifdef VR_TX_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) enq(1, 1 + (i % 3));
        drain(300);
        chk("pkt_cnt0", pkt_cnt[0 +: 32], 0);
        chk("pkt_cnt1", pkt_cnt[32 +: 32], 5);
        chk("pkt_cnt2", pkt_cnt[64 +: 32], 0);
`endif

        // Randomized traffic with sink backpressure and source bubbles.
        do_reset();
        p_rdy_meta = 70;
        p_rdy_data = 70;
        p_dval     = 75;
        for (int i = 0; i < 600; i++) begin
            for (int e = 0; e < N; e++)
                if (tx_meta_q[e].size() < 3 && $urandom_range(99) < 12)
                    enq(e, $urandom_range(4, 1));
            step();
        end
        drain(3000);
        for (int e = 0; e < N; e++) begin
            chk("rand_meta_left", exp_meta_q[e].size(), 0);
            chk("rand_beats_left", exp_beat_q[e].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vr_udp_tx_arb.md
VR_UDP_TX_ARB -- requirements
Module: vr_udp_tx_arb

Interface
REQ-001 Parameter NUM_SRC, default 3, number of engines sharing the UDP TX port (prepare, commit, view-change).
REQ-002 Parameter META_W, default 96, metadata word width.
REQ-003 Parameter DATA_W, default 512, data beat width.
REQ-004 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 src_meta_val  in  NUM_SRC  per-engine metadata valid.
REQ-007 src_meta  in  NUM_SRC*META_W  per-engine metadata, packed, engine 0 in the LSBs.
REQ-008 src_meta_rdy  out  NUM_SRC  per-engine metadata ready.
REQ-009 src_data_val  in  NUM_SRC  per-engine data valid.
REQ-010 src_data  in  NUM_SRC*DATA_W  per-engine data beats, packed.
REQ-011 src_data_last  in  NUM_SRC  per-engine last-beat flag.
REQ-012 src_data_rdy  out  NUM_SRC  per-engine data ready.
REQ-013 dst_meta_val / dst_meta / dst_meta_rdy  out/out/in  1/META_W/1  metadata to the UDP TX block.
REQ-014 dst_data_val / dst_data / dst_data_last / dst_data_rdy  out/out/out/in  1/DATA_W/1/1  data to the UDP TX block.
REQ-015 grant_id  out  $clog2(NUM_SRC)  index of the engine currently holding the port.
REQ-016 busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 States SHALL be IDLE, SEND_META, SEND_DATA.
REQ-018 IDLE, any src_meta_val high: round-robin winner = first set bit at or after rr_ptr (wrapping); grant_id registered; next state SEND_META.
REQ-019 IDLE SHALL assert no src_*_rdy and no dst_*_val.
REQ-020 Arbitration latency: one cycle from meta_val to dst_meta_val.
REQ-021 SEND_META: dst_meta_val = src_meta_val[grant]; dst_meta = src_meta[grant]; src_meta_rdy[grant] = dst_meta_rdy; on handshake, next state SEND_DATA.
REQ-022 SEND_DATA: dst_data_val/data/last forwarded from grant; src_data_rdy[grant] = dst_data_rdy.
REQ-023 SEND_DATA, handshake with last=1: next state IDLE; rr_ptr = grant+1, wrapping at NUM_SRC.
REQ-024 Non-granted engines SHALL see rdy=0 in every state; the grant SHALL NOT change between meta handshake and last-beat handshake.
REQ-025 A single-beat packet (last on first beat) SHALL complete in one SEND_DATA cycle when dst_data_rdy is high.
REQ-026 Back-to-back packets SHALL incur exactly one IDLE cycle between the last-beat handshake and the next SEND_META.
REQ-027 A requester deasserting meta_val after grant SHALL leave the arbiter stalled in SEND_META; no timeout.
REQ-028 All dst/src outputs SHALL be combinational from the registered state and grant only; no input-to-grant combinational path.

Reset
REQ-029 On rst: state=IDLE, rr_ptr=0, grant_id=0, busy=0; all rdy and val outputs 0 in the following cycle.
REQ-030 Reset mid-packet SHALL abandon the packet with no further beats forwarded.

Configuration
REQ-031 Macro VR_TX_ARB_STATS_EN defined: adds output pkt_cnt (NUM_SRC*32), per-engine counters incremented on that engine's last-beat handshake, wrapping at 2^32, cleared by rst.
REQ-032 Macro undefined: no pkt_cnt port and no counters; all other behaviour identical.

Structure
REQ-033 The state enum and NUM_SRC default SHALL live in shared package vr_tx_arb_pkg.
REQ-034 The round-robin pick SHALL be sub-module rr_pick (request vector plus pointer in, one-hot plus index out, combinational).

Verification
REQ-035 Single source: engine 0 sends meta + 2 beats with rdy=1 -> dst_meta at cycle 2, beats at cycles 3-4, busy low at cycle 5.
REQ-036 Contention: all 3 request at once from reset -> grant order 0,1,2, one IDLE cycle between packets.
REQ-037 Fairness: engine 0 requests continuously, engine 2 requests once -> engine 2 served immediately after engine 0's current packet.
REQ-038 Backpressure: dst_data_rdy toggles 1,0,0,1 on a 3-beat packet -> beats held stable, grant_id unchanged, no beats dropped or duplicated.
REQ-039 Reset at beat 2 of 4 -> next cycle all val/rdy are 0, state IDLE, rr_ptr 0.
REQ-040 With VR_TX_ARB_STATS_EN: 5 packets from engine 1 -> pkt_cnt[1]=5, others 0.
